// File: rtl/button_step_ctrl.sv
// button_step_ctrl
//   Manual stepping front end for the LED position display. Each raw push-button
//   passes through a two-flop synchronizer and a debounce filter. A shared FSM
//   then steps a position register with wrap-around. Holding one button
//   auto-repeats after an initial delay. Pressing both buttons locks out stepping
//   until both buttons are released.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   btn_up      raw up button (active-high, asynchronous, bouncy)
//   btn_down    raw down button (active-high, asynchronous, bouncy)
//   pos         current position, 0..NUM_POS-1
//   led         one-hot decode of pos
//   step_pulse  one-cycle strobe, high in the cycle pos/led take a new value
module button_step_ctrl #(
    parameter int NUM_POS         = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [3:0]         pos,
    output logic [NUM_POS-1:0] led,
    output logic               step_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W  = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0]   DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0]   RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [3:0]         POS_LAST   = 4'(NUM_POS - 1);
    localparam logic [NUM_POS-1:0] LED_ONE    = NUM_POS'(1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [1:0] LOCK   = 2'd3;

    // Index 0 is the up button and index 1 is the down button.
    logic [1:0]      raw;
    logic [1:0]      sync_p0;
    logic [1:0]      sync_p1;
    logic [1:0]      deb;
    logic [DB_W-1:0] db_cnt [2];

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             dir_up;
    logic             dir_up_nxt;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_cnt_nxt;
    logic             step_req;
    logic             step_up;
    logic [3:0]       pos_nxt;

    logic held_u;
    logic held_d;
    logic held_b;

    assign raw = {btn_down, btn_up};

    // Synchronizer and debounce stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 2'b00;
            sync_p1 <= 2'b00;
            deb     <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign held_u = deb[0] & ~deb[1];
    assign held_d = deb[1] & ~deb[0];
    assign held_b = deb[0] & deb[1];

    // Step decision stage
    always_comb begin
        state_nxt   = state;
        dir_up_nxt  = dir_up;
        rep_cnt_nxt = '0;
        step_req    = 1'b0;
        step_up     = dir_up;
        case (state)
            IDLE: begin
                if (held_b) begin
                    state_nxt = LOCK;
                end else if (held_u || held_d) begin
                    step_req   = 1'b1;
                    step_up    = held_u;
                    dir_up_nxt = held_u;
                    state_nxt  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (held_b) begin
                    state_nxt = LOCK;
                end else if (!held_u && !held_d) begin
                    state_nxt = IDLE;
                end else if (held_u != dir_up) begin
                    // A direction swap without a release counts as a fresh press.
                    step_req   = 1'b1;
                    step_up    = held_u;
                    dir_up_nxt = held_u;
                    state_nxt  = DELAY;
                end else if (rep_cnt == ((state == DELAY) ? DELAY_LAST : RATE_LAST)) begin
                    step_req  = 1'b1;
                    state_nxt = REPEAT;
                end else begin
                    rep_cnt_nxt = rep_cnt + 1'b1;
                end
            end
            default: begin
                // LOCK is left only when both buttons are up, so releasing one button never steps.
                if (deb == 2'b00) state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        pos_nxt = pos;
        if (step_req) begin
            if (step_up) pos_nxt = (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
            else         pos_nxt = (pos == 4'd0) ? POS_LAST : pos - 4'd1;
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dir_up     <= 1'b1;
            rep_cnt    <= '0;
            pos        <= 4'd0;
            led        <= LED_ONE;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            dir_up     <= dir_up_nxt;
            rep_cnt    <= rep_cnt_nxt;
            step_pulse <= step_req;
            if (step_req) begin
                pos <= pos_nxt;
                led <= LED_ONE << pos_nxt;
            end
        end
    end

endmodule

// File: tb/tb_button_step_ctrl.sv
module tb_button_step_ctrl;

    localparam int NP = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic [3:0]    pos;
    logic [NP-1:0] led;
    logic          step_pulse;

    typedef struct {
        logic [3:0] p;
        int         c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   mpos = 0;

    button_step_ctrl #(
        .NUM_POS(NP), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
        .pos(pos), .led(led), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    function automatic int onehot(input int p);
        return 1 << p;
    endfunction

    // Monitor: every step strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && step_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_step_pos", int'(pos), -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_pos", int'(pos), int'(e.p));
                chk("step_led", int'(led), onehot(int'(e.p)));
                chk("step_cycle", cyc, e.c);
            end
        end
    end

    // Press one button for 'hold' cycles. Steps happen at 7, 27, 35, 43, ... cycles
    // after the raw rise, and only while the debounced release (hold+6) has not yet been seen.
    task automatic press(input bit up, input int hold);
        int c0;
        int t;
        @(posedge clk); #1;
        c0 = cyc;
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        t = 7;
        while (t <= hold + 6) begin
            exp_t e;
            mpos = up ? ((mpos == NP - 1) ? 0 : mpos + 1) : ((mpos == 0) ? NP - 1 : mpos - 1);
            e.p = 4'(mpos);
            e.c = c0 + t;
            exp_q.push_back(e);
            t += (t == 7) ? 20 : 8;
        end
        repeat (hold) @(posedge clk);
        #1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pos", int'(pos), 0);
        chk("reset_led", int'(led), 1);
        chk("reset_step", int'(step_pulse), 0);
        rst = 1'b0;

        // Bouncing input shorter than the debounce window never steps.
        for (int i = 0; i < 20; i++) begin
            btn_up = ~btn_up;
            repeat (2) @(posedge clk);
            #1;
        end
        btn_up = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_pos", int'(pos), 0);
        chk("glitch_led", int'(led), 1);

        // Single clean press: one step, 7 cycles after the raw rise.
        press(1'b1, 10);
        chk("t1_pos", int'(pos), 1);
        chk("t1_led", int'(led), 'h002);

        // Wrap in both directions: 1 -> 0 -> 9 -> 0 -> 9.
        press(1'b0, 10);
        press(1'b0, 10);
        chk("wrap_down_pos", int'(pos), 9);
        press(1'b1, 10);
        chk("wrap_up_pos", int'(pos), 0);
        chk("wrap_up_led", int'(led), 'h001);
        press(1'b0, 10);
        chk("wrap_down_led", int'(led), 'h200);

        // Walk down to 5, then hold down for an initial step plus three repeats (5 -> 1).
        for (int i = 0; i < 4; i++) press(1'b0, 10);
        chk("t4_start_pos", int'(pos), 5);
        press(1'b0, 42);
        chk("t4_end_pos", int'(pos), 1);

        // Up, then both (lock), release up while down still held, then release all.
        @(posedge clk); #1;
        c0 = cyc;
        btn_up = 1'b1;
        e.p = 4'd2; e.c = c0 + 7; exp_q.push_back(e);
        repeat (8) @(posedge clk); #1;
        btn_down = 1'b1;
        repeat (12) @(posedge clk); #1;
        btn_up = 1'b0;
        repeat (10) @(posedge clk); #1;
        btn_down = 1'b0;
        repeat (30) @(posedge clk); #1;
        chk("lock_pos", int'(pos), 2);
        chk("lock_queue", exp_q.size(), 0);
        mpos = 2;

        // Auto-repeat from 2 up to 7, reset mid-repeat with the button still held.
        @(posedge clk); #1;
        c0 = cyc;
        btn_up = 1'b1;
        e.p = 4'd3; e.c = c0 + 7;  exp_q.push_back(e);
        e.p = 4'd4; e.c = c0 + 27; exp_q.push_back(e);
        e.p = 4'd5; e.c = c0 + 35; exp_q.push_back(e);
        e.p = 4'd6; e.c = c0 + 43; exp_q.push_back(e);
        e.p = 4'd7; e.c = c0 + 51; exp_q.push_back(e);
        repeat (52) @(posedge clk); #1;
        chk("pre_reset_pos", int'(pos), 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_reset_pos", int'(pos), 0);
        chk("mid_reset_led", int'(led), 1);
        chk("mid_reset_step", int'(step_pulse), 0);
        // Fresh debounce after reset: step 7 cycles after the reset edge.
        e.p = 4'd1; e.c = c0 + 60; exp_q.push_back(e);
        repeat (8) @(posedge clk); #1;
        btn_up = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("final_pos", int'(pos), 1);
        chk("final_led", int'(led), 'h002);
        chk("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
